// File: rtl/i2c_cfg_pkg.sv
// Shared state encoding and sizing helpers for the I2C configuration sequencer.
`timescale 1ns/1ps
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_DELAY,
    S_VERIFY,
    S_DONE,
    S_FAIL
  } state_t;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_w(input longint max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Delay-marker address: all ones at the given address width.
  function automatic logic [31:0] default_delay_addr(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

endpackage

// File: rtl/i2c_cfg_delay_timer.sv
// Load-and-count-down timer; done_o is high on the last cycle of a loaded interval.
`timescale 1ns/1ps
module i2c_cfg_delay_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // A load of N gives max(N,1) cycles of run before done_o.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = load_val_i;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q <= CNT_W'(1)) run_d = 1'b0;
      else                    cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks an {addr,data} table into an I2C write master with power-up wait, delay entries and NACK retry.
// Optional readback verify of every write is enabled by defining CFG_READBACK_EN.
`timescale 1ns/1ps
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int REG_ADDR_W     = 8,
  parameter int REG_DATA_W     = 8,
  parameter int INDEX_W        = 8,
  parameter int POWERUP_CYCLES = 20000,
  parameter logic [REG_ADDR_W-1:0] DELAY_ADDR = REG_ADDR_W'(default_delay_addr(REG_ADDR_W)),
  parameter int DELAY_TICK     = 50000,
  parameter int RETRY_MAX      = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic [INDEX_W-1:0]               lut_index,
  input  logic [REG_ADDR_W+REG_DATA_W-1:0] lut_data,
  input  logic [INDEX_W-1:0]               lut_size,
  output logic                             wr_req,
  output logic [REG_ADDR_W-1:0]            wr_addr,
  output logic [REG_DATA_W-1:0]            wr_data,
  input  logic                             wr_ack,
  input  logic                             wr_err,
  output logic                             rd_req,
  input  logic [REG_DATA_W-1:0]            rd_data,
  input  logic                             rd_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [INDEX_W-1:0]               err_index
);

  localparam int     AW      = REG_ADDR_W;
  localparam int     DW      = REG_DATA_W;
  localparam longint DLY_MAX = ((longint'(1) << DW) - 1) * longint'(DELAY_TICK);
  localparam longint TMR_MAX = (DLY_MAX > longint'(POWERUP_CYCLES)) ? DLY_MAX : longint'(POWERUP_CYCLES);
  localparam int     TMR_W   = cnt_w(TMR_MAX);
  localparam int     RTY_W   = cnt_w(longint'(RETRY_MAX));
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRY_MAX - 1);

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               wr_req_q, wr_req_d;
  logic [INDEX_W-1:0] err_idx_q, err_idx_d;
  logic               attempt_bad;
  logic               tmr_load, tmr_done;
  logic [TMR_W-1:0]   tmr_val;

`ifdef CFG_READBACK_EN
  logic rd_req_q, rd_req_d;
`endif

  i2c_cfg_delay_timer #(.CNT_W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    retry_d     = retry_q;
    wr_req_d    = wr_req_q;
    err_idx_d   = err_idx_q;
    attempt_bad = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
`ifdef CFG_READBACK_EN
    rd_req_d    = rd_req_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d   = S_PWR_WAIT;
          idx_d     = '0;
          retry_d   = '0;
          err_idx_d = '0;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(POWERUP_CYCLES);
        end
      end
      S_PWR_WAIT: if (tmr_done) state_d = S_FETCH;
      S_FETCH: begin
        if (idx_q >= lut_size) begin
          state_d = S_DONE;
        end else begin
          addr_d = lut_data[AW+DW-1:DW];
          data_d = lut_data[DW-1:0];
          if (lut_data[AW+DW-1:DW] == DELAY_ADDR) begin
            state_d  = S_DELAY;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(lut_data[DW-1:0]) * TMR_W'(DELAY_TICK);
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      // wr_req rises on entry to WAIT_ACK so a retry always shows a low cycle first.
      S_ISSUE: begin
        wr_req_d = 1'b1;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (wr_err) begin
          wr_req_d    = 1'b0;
          attempt_bad = 1'b1;
        end else if (wr_ack) begin
          wr_req_d = 1'b0;
`ifdef CFG_READBACK_EN
          rd_req_d = 1'b1;
          state_d  = S_VERIFY;
`else
          idx_d    = idx_q + INDEX_W'(1);
          retry_d  = '0;
          state_d  = S_FETCH;
`endif
        end
      end
      S_DELAY: begin
        if (tmr_done) begin
          idx_d   = idx_q + INDEX_W'(1);
          state_d = S_FETCH;
        end
      end
`ifdef CFG_READBACK_EN
      S_VERIFY: begin
        if (rd_valid) begin
          rd_req_d = 1'b0;
          if (rd_data == data_q) begin
            idx_d   = idx_q + INDEX_W'(1);
            retry_d = '0;
            state_d = S_FETCH;
          end else begin
            attempt_bad = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (attempt_bad) begin
      if (retry_q < RTY_LAST) begin
        retry_d = retry_q + RTY_W'(1);
        state_d = S_ISSUE;
      end else begin
        err_idx_d = idx_q;
        state_d   = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      retry_q   <= '0;
      wr_req_q  <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      retry_q   <= retry_d;
      wr_req_q  <= wr_req_d;
      err_idx_q <= err_idx_d;
    end
  end

`ifdef CFG_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_req_q <= 1'b0;
    else        rd_req_q <= rd_req_d;
  end
  assign rd_req = rd_req_q;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_data, rd_valid};
  assign rd_req    = 1'b0;
`endif

  assign lut_index = idx_q;
  assign wr_req    = wr_req_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign err_index = err_idx_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_FAIL);

endmodule
